alu_issuer: RTL and testbench
=============================

# alu_issuer

Command-side initiator for the team's combinational 16-bit ALU. Accepts operation requests (opcode, two operands, tag) over a valid/ready handshake, buffers them in a small FIFO, and drives the ALU's operand and select lines. It holds those lines stable for the required settle time, captures the ALU results, and returns them with the tag over a second valid/ready handshake. It sits between the instruction sequencer and the ALU and isolates the ALU from back-pressure.

## Interface
- WIDTH, 16, operand/result width; must match the ALU
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- MULDIV_WAIT, 2, extra settle cycles for opcodes 4 (mul) and 5 (div/mod); 0 allowed

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; equals FIFO not full
- cmd_op  in  4  ALU select code
- cmd_a / cmd_b  in  WIDTH  operands (signed)
- cmd_tag  in  4  opaque tag, returned with result
- alu_in1 / alu_in2  out  WIDTH  registered ALU operands
- alu_select  out  4  registered ALU select
- alu_out1 / alu_out2  in  WIDTH  ALU results
- alu_overflow  in  1  ALU overflow
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_lo / rsp_hi  out  WIDTH  captured out1 / out2
- rsp_ovf  out  1  captured overflow
- rsp_err  out  1  request rejected (illegal opcode or trapped divide)
- rsp_tag  out  4  tag of the request

## Operation
- Push on cmd_valid && cmd_ready. No pop on an empty FIFO and no push-to-pop bypass: a command written this edge is poppable no earlier than the next edge.
- FSM states: IDLE, DRIVE, WAIT, HOLD.
- IDLE: if FIFO non-empty, pop; load alu_in1/alu_in2/alu_select and the tag register; → DRIVE.
- DRIVE (1 cycle): opcode 4 or 5 with MULDIV_WAIT>0 → WAIT with counter=MULDIV_WAIT; otherwise capture → HOLD.
- WAIT: decrement the counter; on the edge where it reaches 1, capture → HOLD.
- Capture rules:
  - rsp_lo=alu_out1.
  - rsp_hi=alu_out2 for ops 4/5, else 0.
  - rsp_ovf=alu_overflow for ops 0/1, else 0.
  - rsp_err=0.
- Opcodes 10–15: ALU lines are still loaded, but capture forces lo=hi=0, ovf=0, err=1. Latency is the same as a simple op.
- HOLD: rsp_valid=1 and outputs stable until rsp_valid && rsp_ready. On that edge, if the FIFO is non-empty, pop and load → DRIVE (back-to-back); else → IDLE.
- alu_* outputs hold their last values outside DRIVE/WAIT.
- Reset (any time, including mid-WAIT or HOLD):
  - FIFO emptied; state=IDLE.
  - rsp_valid=0, cmd_ready=1 after reset releases.
  - all alu_* and rsp_* registers = 0.
  - in-flight and queued commands are discarded with no response.

## Timing
- Simple op, empty pipeline: accepted at edge E0, popped/driven at E1, captured at E2. rsp_valid is high from after E2, i.e. 2 cycles.
- Ops 4/5: 2+MULDIV_WAIT cycles.
- Back-to-back with rsp_ready held high: one result per 2 cycles (simple ops), since HOLD→DRIVE→HOLD.
- Responses are returned strictly in command order.
- cmd_ready deasserts the cycle after the FIFO_DEPTH-th unpopped push. It reasserts the cycle after a pop.

## Configuration
- ALU_DIV0_TRAP_EN defined:
  - opcode 5 with cmd_b==0 skips WAIT.
  - Capture at the end of DRIVE forces lo=hi=0, ovf=0, err=1.
  - Latency is 2 cycles.
- Not defined: opcode 5 with divisor 0 is issued normally and returns whatever the ALU produces, with err=0.

## Test plan
- Op 0, a=3, b=4, tag=5, rsp_ready=1 → rsp_valid exactly 2 cycles after accept; lo=7, hi=0, ovf=0, err=0, tag=5.
- Op 4, a=0x0100, b=0x0100, MULDIV_WAIT=2 → response 4 cycles after accept; hi=0x0001, lo=0x0000; alu_* stable throughout DRIVE/WAIT.
- Push 6 commands (ops 2,3,6,7,0,1) with rsp_ready=0 → cmd_ready low after 4 FIFO entries. Then release rsp_ready → all 6 responses in order with correct tags, one per 2 cycles.
- Op 12, a=1, b=1 → err=1, lo=hi=0, ovf=0, latency 2. Op 5, a=9, b=0 → with ALU_DIV0_TRAP_EN: err=1, lo=hi=0, latency 2; without it: err=0, latency 2+MULDIV_WAIT.
- Assert rst during WAIT of an op 5 with 2 commands queued → rsp_valid=0, cmd_ready=1, all outputs 0. No responses ever appear for the discarded commands; a new op 0 afterwards returns normally with 2-cycle latency.
- Hold rsp_ready=0 for 10 cycles in HOLD → rsp_* unchanged every cycle; response consumed exactly once when rsp_ready rises.

Source files
------------

// File: rtl/alu_issuer.sv
// alu_issuer: queues tagged ALU commands, drives a combinational ALU with settle time and returns captured results.
// Optional feature: define ALU_DIV0_TRAP_EN to reject opcode 5 with a zero divisor instead of issuing it.

module alu_issuer #(
  parameter int WIDTH       = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int MULDIV_WAIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_tag,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_select,
  input  logic [WIDTH-1:0] alu_out1,
  input  logic [WIDTH-1:0] alu_out2,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_lo,
  output logic [WIDTH-1:0] rsp_hi,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [3:0]       rsp_tag
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 2 * WIDTH + 8;
  localparam int CW = $clog2(MULDIV_WAIT + 2);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] WAIT_INIT = CW'(MULDIV_WAIT);
  localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, HOLD} state_t;

  // Command FIFO: entry packs {op, a, b, tag}
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push;
  logic          pop;
  logic          fifo_empty;

  logic [EW-1:0]    head_entry;
  logic [3:0]       head_op;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic [3:0]       head_tag;

  state_t           state_q, state_d;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
  logic [WIDTH-1:0] alu_in2_q, alu_in2_d;
  logic [3:0]       alu_select_q, alu_select_d;
  logic [3:0]       issue_tag_q, issue_tag_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_lo_q, rsp_lo_d;
  logic [WIDTH-1:0] rsp_hi_q, rsp_hi_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_err_q, rsp_err_d;
  logic [3:0]       rsp_tag_q, rsp_tag_d;

  logic capture;
  logic op_muldiv;
  logic op_addsub;
  logic op_illegal;
  logic div0_trap;
  logic reject;

  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = (count_q != FULL_CNT);
  assign push       = cmd_valid && cmd_ready;

  assign head_entry = fifo_mem[rd_ptr_q];
  assign head_op    = head_entry[EW-1 -: 4];
  assign head_a     = head_entry[EW-5 -: WIDTH];
  assign head_b     = head_entry[WIDTH+3 -: WIDTH];
  assign head_tag   = head_entry[3:0];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b, cmd_tag};
    end
  end

  // Opcode classes are decoded from the registered select, i.e. the op in flight
  assign op_muldiv  = (alu_select_q == 4'd4) || (alu_select_q == 4'd5);
  assign op_addsub  = (alu_select_q == 4'd0) || (alu_select_q == 4'd1);
  assign op_illegal = (alu_select_q >= 4'd10);

`ifdef ALU_DIV0_TRAP_EN
  assign div0_trap = (alu_select_q == 4'd5) && (alu_in2_q == '0);
`else
  assign div0_trap = 1'b0;
`endif

  assign reject = op_illegal || div0_trap;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    alu_select_d = alu_select_q;
    issue_tag_d  = issue_tag_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_lo_d     = rsp_lo_q;
    rsp_hi_d     = rsp_hi_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_err_d    = rsp_err_q;
    rsp_tag_d    = rsp_tag_q;
    pop          = 1'b0;
    capture      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (op_muldiv && !div0_trap && (MULDIV_WAIT > 0)) begin
          wait_cnt_d = WAIT_INIT;
          state_d    = WAIT;
        end else begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      WAIT: begin
        if (wait_cnt_q == WAIT_ONE) begin
          capture = 1'b1;
          state_d = HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_ONE;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      alu_in1_d    = head_a;
      alu_in2_d    = head_b;
      alu_select_d = head_op;
      issue_tag_d  = head_tag;
    end

    if (capture) begin
      rsp_valid_d = 1'b1;
      rsp_tag_d   = issue_tag_q;
      rsp_err_d   = reject;
      rsp_lo_d    = reject ? '0 : alu_out1;
      rsp_hi_d    = (!reject && op_muldiv) ? alu_out2 : '0;
      rsp_ovf_d   = !reject && op_addsub && alu_overflow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_select_q <= '0;
      issue_tag_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_lo_q     <= '0;
      rsp_hi_q     <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_tag_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      alu_select_q <= alu_select_d;
      issue_tag_q  <= issue_tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_lo_q     <= rsp_lo_d;
      rsp_hi_q     <= rsp_hi_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
      rsp_tag_q    <= rsp_tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign alu_select = alu_select_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_lo     = rsp_lo_q;
  assign rsp_hi     = rsp_hi_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_tag    = rsp_tag_q;

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) pop |-> !fifo_empty);
  a_count_bound:  assert property (@(posedge clk) disable iff (rst) count_q <= FULL_CNT);

endmodule

// File: tb/tb_alu_issuer.sv
// tb_alu_issuer: directed vectors against a behavioural ALU; a scoreboard queue feeds a monitor checking every response.

module tb_alu_issuer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic [3:0]  cmd_tag = '0;
  logic [15:0] alu_in1, alu_in2;
  logic [3:0]  alu_select;
  logic [15:0] alu_out1, alu_out2;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_lo, rsp_hi;
  logic        rsp_ovf, rsp_err;
  logic [3:0]  rsp_tag;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_wait = 0;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        ovf;
    logic        err;
    logic [3:0]  tag;
    int          acc;
    int          lat;
    int          gap;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issuer #(.WIDTH(16), .FIFO_DEPTH(4), .MULDIV_WAIT(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_select(alu_select),
    .alu_out1(alu_out1), .alu_out2(alu_out2), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
  );

  // Behavioural ALU; out2/overflow carry junk on ops where the issuer must mask them
  logic signed [15:0] sa, sb;
  logic signed [31:0] prod;
  always_comb begin
    sa           = alu_in1;
    sb           = alu_in2;
    prod         = sa * sb;
    alu_out1     = alu_in1 ^ alu_in2;
    alu_out2     = 16'hA5A5;
    alu_overflow = 1'b1;
    case (alu_select)
      4'd0: begin
        alu_out1     = alu_in1 + alu_in2;
        alu_overflow = (alu_in1[15] == alu_in2[15]) && (alu_out1[15] != alu_in1[15]);
      end
      4'd1: begin
        alu_out1     = alu_in1 - alu_in2;
        alu_overflow = (alu_in1[15] != alu_in2[15]) && (alu_out1[15] != alu_in1[15]);
      end
      4'd2: alu_out1 = alu_in1 & alu_in2;
      4'd3: alu_out1 = alu_in1 | alu_in2;
      4'd4: begin
        alu_out1 = prod[15:0];
        alu_out2 = prod[31:16];
      end
      4'd5: begin
        if (alu_in2 == 16'h0000) begin
          alu_out1 = 16'hFFFF;
          alu_out2 = alu_in1;
        end else begin
          alu_out1 = sa / sb;
          alu_out2 = sa % sb;
        end
      end
      4'd6: alu_out1 = alu_in1 ^ alu_in2;
      4'd7: alu_out1 = alu_in1 << alu_in2[3:0];
      default: alu_out1 = alu_in1 ^ alu_in2;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called right after a posedge (+#1); returns right after the accepting posedge (+#1)
  task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] tag, input bit track,
                      input logic [15:0] elo, input logic [15:0] ehi, input logic eovf,
                      input logic eerr, input int lat, input int gap);
    bit   rd;
    bit   ok;
    exp_t e;
    ok        = 1'b0;
    last_wait = 0;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rd = cmd_ready;
      @(posedge clk);
      #1;
      if (rd) begin
        ok = 1'b1;
        break;
      end
      last_wait++;
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept_timeout: tag %0d never accepted, required accept within 50 cycles", tag);
    end else if (track) begin
      e.lo  = elo;
      e.hi  = ehi;
      e.ovf = eovf;
      e.err = eerr;
      e.tag = tag;
      e.acc = cyc;
      e.lat = lat;
      e.gap = gap;
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0 && !rsp_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: samples on the falling edge, pops one expectation per new response
  initial begin
    bit          active;
    int          last_cyc;
    exp_t        e;
    logic [15:0] h_lo, h_hi;
    logic        h_ovf, h_err;
    logic [3:0]  h_tag;
    active   = 1'b0;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
      end else if (rsp_valid) begin
        if (!active) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: tag %0d lo 0x%0h, required no response", rsp_tag, rsp_lo);
          end else begin
            e = sb_q.pop_front();
            chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
            chk("rsp_lo", 32'(rsp_lo), 32'(e.lo));
            chk("rsp_hi", 32'(rsp_hi), 32'(e.hi));
            chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            if (e.lat >= 0) chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
            if (e.gap >= 0) chk("rsp_gap", 32'(cyc - last_cyc), 32'(e.gap));
          end
          last_cyc = cyc;
          h_lo  = rsp_lo;
          h_hi  = rsp_hi;
          h_ovf = rsp_ovf;
          h_err = rsp_err;
          h_tag = rsp_tag;
          active = 1'b1;
        end else begin
          chk("rsp_stable", {rsp_lo, rsp_hi[9:0], rsp_ovf, rsp_err, rsp_tag},
                            {h_lo, h_hi[9:0], h_ovf, h_err, h_tag});
        end
        if (rsp_ready) active = 1'b0;
      end else if (active) begin
        checks++;
        failures++;
        $display("FAIL rsp_dropped: rsp_valid fell before handshake, required held high");
        active = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_alu_lines", {alu_in1, alu_in2[11:0], alu_select}, 0);
    chk("reset_rsp_data", {rsp_lo, rsp_hi[9:0], rsp_ovf, rsp_err, rsp_tag}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk);
    #1;

    // Simple add, 2-cycle latency
    push(4'd0, 16'd3, 16'd4, 4'd5, 1'b1, 16'd7, 16'd0, 1'b0, 1'b0, 2, -1);
    drain();

    // Multiply: extra settle cycles, ALU lines must not move during DRIVE/WAIT
    push(4'd4, 16'h0100, 16'h0100, 4'd2, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0, 4, -1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("alu_hold_mul", {alu_in1, alu_in2, 4'h0, alu_select}, {16'h0100, 16'h0100, 4'h0, 4'd4});
    end
    drain();

    // Signed divide: -7 / 2 -> quotient -3, remainder -1
    push(4'd5, 16'hFFF9, 16'h0002, 4'd3, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 4, -1);
    drain();

    // Illegal opcode rejected with simple-op latency
    push(4'd12, 16'd1, 16'd1, 4'd7, 1'b1, 16'd0, 16'd0, 1'b0, 1'b1, 2, -1);
    drain();

    // Divide by zero
`ifdef ALU_DIV0_TRAP_EN
    push(4'd5, 16'd9, 16'd0, 4'd9, 1'b1, 16'd0, 16'd0, 1'b0, 1'b1, 2, -1);
`else
    push(4'd5, 16'd9, 16'd0, 4'd9, 1'b1, 16'hFFFF, 16'h0009, 1'b0, 1'b0, 4, -1);
`endif
    drain();

    // Fill FIFO under back-pressure, then release: in-order, one result per 2 cycles
    rsp_ready = 1'b0;
    push(4'd2, 16'h00F0, 16'h0FF0, 4'd8,  1'b1, 16'h00F0, 16'd0, 1'b0, 1'b0, 2, -1);
    push(4'd3, 16'h1200, 16'h0034, 4'd9,  1'b1, 16'h1234, 16'd0, 1'b0, 1'b0, -1, -1);
    push(4'd6, 16'hFFFF, 16'h0F0F, 4'd10, 1'b1, 16'hF0F0, 16'd0, 1'b0, 1'b0, -1, 2);
    push(4'd7, 16'h0001, 16'h0004, 4'd11, 1'b1, 16'h0010, 16'd0, 1'b0, 1'b0, -1, 2);
    push(4'd0, 16'h7FFF, 16'h0001, 4'd12, 1'b1, 16'h8000, 16'd0, 1'b1, 1'b0, -1, 2);
    @(negedge clk);
    chk("cmd_ready_full", 32'(cmd_ready), 0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    push(4'd1, 16'h8000, 16'h0001, 4'd13, 1'b1, 16'h7FFF, 16'd0, 1'b1, 1'b0, -1, 2);
    chk("cmd_ready_reassert_wait", 32'(last_wait), 1);
    drain();

    // Long stall in HOLD: outputs stable, single consumption
    rsp_ready = 1'b0;
    push(4'd3, 16'h1200, 16'h0034, 4'd1, 1'b1, 16'h1234, 16'd0, 1'b0, 1'b0, 2, -1);
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rsp_consumed_once", {31'd0, rsp_valid}, 0);
    chk("hold_sb_empty", 32'(sb_q.size()), 0);

    // Reset mid-WAIT with two commands queued: everything discarded
    push(4'd5, 16'd20, 16'd3, 4'd4, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, -1, -1);
    push(4'd0, 16'd1, 16'd2, 4'd14, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, -1, -1);
    push(4'd1, 16'd5, 16'd2, 4'd15, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, -1, -1);
    rst = 1'b1;
    #1;
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_mid_alu_lines", {alu_in1, alu_in2[11:0], alu_select}, 0);
    chk("rst_mid_rsp_data", {rsp_lo, rsp_hi[9:0], rsp_ovf, rsp_err, rsp_tag}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("post_rst_idle", {30'd0, cmd_ready, rsp_valid}, 32'h2);
    push(4'd0, 16'h0010, 16'hFFFF, 4'd6, 1'b1, 16'h000F, 16'd0, 1'b0, 1'b0, 2, -1);
    drain();

    chk("sb_empty_end", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
